bram_window_reader: RTL
=======================

BRAM_WINDOW_READER -- requirements
Module: bram_window_reader

Interface
REQ-001 Parameter WIDTH, default 205: image width in pixels.
REQ-002 Parameter HEIGHT, default 308: image height in pixels; WIDTH*HEIGHT is the BRAM depth (63140).
REQ-003 Parameter ADDR_WIDTH, default 16: BRAM address width.
REQ-004 Parameter COL_WIDTH, default 8 and NB_COL, default 3: pixel = NB_COL colour columns of COL_WIDTH bits (24-bit RGB).
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle pulse; begins a full-image raster scan.
REQ-008 bram_addr  out  ADDR_WIDTH  read address to the BRAM.
REQ-009 bram_re  out  1  BRAM read enable.
REQ-010 bram_do  in  NB_COL*COL_WIDTH  BRAM read data, valid the cycle after bram_re.
REQ-011 win_data  out  9*NB_COL*COL_WIDTH  3x3 window; slot k at bits [(k+1)*24-1:k*24]; k=0..8 = tl,tc,tr,l,c,r,bl,bc,br.
REQ-012 win_edge  out  1  window centre is on row 0/HEIGHT-1 or column 0/WIDTH-1.
REQ-013 win_valid  out  1  win_data/win_edge/win_addr valid.
REQ-014 win_ready  in  1  consumer accepts window.
REQ-015 win_addr  out  ADDR_WIDTH  centre address = row*WIDTH+col.
REQ-016 busy  out  1  scan in progress; done  out  1  one-cycle pulse at scan end.

Function
REQ-017 FSM states: IDLE, FETCH, EMIT, DONE.
REQ-018 IDLE -> FETCH on start; start ignored in any other state.
REQ-019 Pixels visited in raster order, addr 0 to WIDTH*HEIGHT-1; row/col counters wrap col WIDTH-1 -> 0 with row increment.
REQ-020 Interior pixel: FETCH issues 9 reads on consecutive cycles, bram_re=1, order tl..br, addr = c-WIDTH-1, c-WIDTH, c-WIDTH+1, c-1, c, c+1, c+WIDTH-1, c+WIDTH, c+WIDTH+1.
REQ-021 Edge pixel: FETCH issues only the centre read; the 8 neighbour slots are zero; win_edge=1.
REQ-022 Each bram_do captured into its slot the cycle after its read; FETCH -> EMIT after last capture: win_valid rises 10 cycles (interior) / 2 cycles (edge) after FETCH entry.
REQ-023 bram_re=0 in IDLE, EMIT, DONE; no address outside 0..WIDTH*HEIGHT-1 is ever issued.
REQ-024 EMIT: win_valid=1; win_data/win_edge/win_addr held stable while win_ready=0.
REQ-025 Handshake on win_valid&&win_ready: last pixel -> DONE, else next pixel -> FETCH on the following cycle; win_valid drops in that cycle.
REQ-026 win_ready asserted before win_valid has no effect; no window is skipped or duplicated.
REQ-027 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in FETCH and EMIT only.
REQ-028 Address arithmetic at ADDR_WIDTH bits, no truncation for legal parameters.

Reset
REQ-029 rst_n low at any time, including mid-FETCH or EMIT: state IDLE, bram_re=0, bram_addr=0, win_valid=0, win_data=0, win_edge=0, win_addr=0, busy=0, done=0, counters 0; the in-progress scan is abandoned.
REQ-030 After reset release, no reads until a new start.

Configuration
REQ-031 Macro WIN_STALL_CNT_EN defined: extra output stall_cnt (32 bits) counts cycles with win_valid=1 && win_ready=0; cleared on start and on reset; saturates at all-ones.
REQ-032 Macro undefined: stall_cnt port and its logic absent; all other behaviour identical.

Verification (WIDTH=4, HEIGHT=3, BRAM preloaded with RAM[a]=a)
REQ-033 start, win_ready=1 -> 12 windows, win_addr 0..11 in order; done pulses once; busy low afterwards.
REQ-034 Pixel 5 -> bram_addr sequence 0,1,2,4,5,6,8,9,10 on 9 consecutive cycles; win_edge=0; slot k = that address; win_valid 10 cycles after FETCH entry.
REQ-035 Pixel 0 -> single read of addr 0; slots other than c = 0; win_edge=1; win_valid 2 cycles after FETCH entry.
REQ-036 win_ready held low 7 cycles at pixel 6 -> win_data constant, no new reads; with WIN_STALL_CNT_EN stall_cnt=7 at scan end.
REQ-037 rst_n low during pixel 5 FETCH -> all outputs zero immediately; start pulse during busy ignored; new start rescans from addr 0.

Source files
------------

// File: rtl/bram_window_reader_if.sv
// Window output channel of bram_window_reader: 3x3 pixel window, centre address and edge flag,
// with a valid/ready handshake. The reader drives the master side, the consumer the slave side.
interface bram_window_reader_if #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned PIX_WIDTH  = 24
);
    logic [9*PIX_WIDTH-1:0] win_data;
    logic                   win_edge;
    logic                   win_valid;
    logic                   win_ready;
    logic [ADDR_WIDTH-1:0]  win_addr;

    modport master (output win_data, win_edge, win_valid, win_addr, input win_ready);
    modport slave  (input win_data, win_edge, win_valid, win_addr, output win_ready);
endinterface

// File: rtl/bram_window_reader.sv
// Raster-scan 3x3 window fetcher over a BRAM-resident image; edge pixels return the centre only.
// Optional macro WIN_STALL_CNT_EN adds a saturating count of consumer-stall cycles (stall_cnt).
module bram_window_reader #(
    parameter int unsigned WIDTH      = 205,
    parameter int unsigned HEIGHT     = 308,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned COL_WIDTH  = 8,
    parameter int unsigned NB_COL     = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [ADDR_WIDTH-1:0]        bram_addr,
    output logic                         bram_re,
    input  logic [NB_COL*COL_WIDTH-1:0]  bram_do,
    bram_window_reader_if.master         win,
    output logic                         busy,
    output logic                         done
`ifdef WIN_STALL_CNT_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);
    localparam int unsigned PIX_W  = NB_COL * COL_WIDTH;
    localparam int unsigned WIN_W  = 9 * PIX_W;
    localparam int unsigned ROW_W  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned SLOT_W = 4;

    localparam logic [SLOT_W-1:0]     SLOT_CTR  = SLOT_W'(4);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(8);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ADDR_WIDTH-1:0]   ctr_q, ctr_d;
    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic                    cap_en_q, cap_en_d;
    logic [SLOT_W-1:0]       cap_slot_q, cap_slot_d;
    logic                    re_q, re_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WIN_W-1:0]        data_q, data_d;
    logic                    edge_q, edge_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [ROW_W-1:0]        inc_row;
    logic [COL_W-1:0]        inc_col;
    logic                    load_pix;
    logic                    lp_edge;
    logic [ROW_W-1:0]        lp_row;
    logic [COL_W-1:0]        lp_col;
    logic [ADDR_WIDTH-1:0]   lp_ctr;

    // Neighbour address for slot s (row-major tl..br) around centre c.
    function automatic logic [ADDR_WIDTH-1:0] nbr_addr(input logic [ADDR_WIDTH-1:0] c,
                                                       input logic [SLOT_W-1:0]     s);
        logic [1:0] r;
        logic [1:0] q;
        r = 2'(s / SLOT_W'(3));
        q = 2'(s % SLOT_W'(3));
        return c - ADDR_WIDTH'(WIDTH) - ADDR_WIDTH'(1)
                 + ADDR_WIDTH'(r) * ADDR_WIDTH'(WIDTH) + ADDR_WIDTH'(q);
    endfunction

    function automatic logic is_edge(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return (r == '0) || (r == ROW_W'(HEIGHT - 1)) || (c == '0) || (c == COL_W'(WIDTH - 1));
    endfunction

    // Raster successor of the current pixel.
    always_comb begin
        inc_col = col_q + COL_W'(1);
        inc_row = row_q;
        if (col_q == COL_W'(WIDTH - 1)) begin
            inc_col = '0;
            inc_row = row_q + ROW_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        ctr_d      = ctr_q;
        slot_d     = slot_q;
        cap_en_d   = re_q;
        cap_slot_d = slot_q;
        re_d       = 1'b0;
        addr_d     = addr_q;
        data_d     = data_q;
        edge_d     = edge_q;
        valid_d    = valid_q;
        waddr_d    = waddr_q;
        done_d     = 1'b0;
        load_pix   = 1'b0;
        lp_edge    = 1'b0;
        lp_row     = '0;
        lp_col     = '0;
        lp_ctr     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load_pix = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_FETCH: begin
                if (re_q && !edge_q && (slot_q != SLOT_LAST)) begin
                    re_d   = 1'b1;
                    slot_d = slot_q + SLOT_W'(1);
                    addr_d = nbr_addr(ctr_q, slot_q + SLOT_W'(1));
                end
                for (int k = 0; k < 9; k++) begin
                    if (cap_en_q && (cap_slot_q == SLOT_W'(k))) begin
                        data_d[k*PIX_W +: PIX_W] = bram_do;
                    end
                end
                // Last capture lands: slot 8 for interior pixels, the centre slot for edges.
                if (cap_en_q && (edge_q || (cap_slot_q == SLOT_LAST))) begin
                    state_d = S_EMIT;
                    valid_d = 1'b1;
                end
            end
            S_EMIT: begin
                if (valid_q && win.win_ready) begin
                    valid_d = 1'b0;
                    if (ctr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        load_pix = 1'b1;
                        lp_row   = inc_row;
                        lp_col   = inc_col;
                        lp_ctr   = ctr_q + ADDR_WIDTH'(1);
                        state_d  = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering FETCH for a new pixel: first read goes out on the entry cycle.
        if (load_pix) begin
            lp_edge = is_edge(lp_row, lp_col);
            row_d   = lp_row;
            col_d   = lp_col;
            ctr_d   = lp_ctr;
            edge_d  = lp_edge;
            data_d  = '0;
            waddr_d = lp_ctr;
            re_d    = 1'b1;
            slot_d  = lp_edge ? SLOT_CTR : '0;
            addr_d  = lp_edge ? lp_ctr : nbr_addr(lp_ctr, '0);
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_EMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            col_q      <= '0;
            ctr_q      <= '0;
            slot_q     <= '0;
            cap_en_q   <= 1'b0;
            cap_slot_q <= '0;
            re_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            edge_q     <= 1'b0;
            valid_q    <= 1'b0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            ctr_q      <= ctr_d;
            slot_q     <= slot_d;
            cap_en_q   <= cap_en_d;
            cap_slot_q <= cap_slot_d;
            re_q       <= re_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            edge_q     <= edge_d;
            valid_q    <= valid_d;
            waddr_q    <= waddr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bram_addr     = addr_q;
    assign bram_re       = re_q;
    assign win.win_data  = data_q;
    assign win.win_edge  = edge_q;
    assign win.win_valid = valid_q;
    assign win.win_addr  = waddr_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef WIN_STALL_CNT_EN
    logic [31:0] stall_q;

    // Cycles a window waited on the consumer; restarts with each accepted scan start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            stall_q <= '0;
        end else if (valid_q && !win.win_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'(1);
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
